phys_reg_file: RTL and testbench

Physical register file with per-register ready bits, sitting directly downstream of the functional-unit block. It consumes the `N` CDB lanes to write results and set ready bits. It serves `2N` source-operand reads to dispatch/issue with same-cycle CDB bypass. Dispatch allocations clear ready bits, and a pipeline nuke restores them.

---
 rtl/phys_reg_file_pkg.sv | 28 ++
 rtl/prf_bypass_mux.sv | 32 +++
 rtl/phys_reg_file.sv | 82 ++++++++
 tb/tb_phys_reg_file.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_file_pkg.sv
// Shared sizing parameters and CDB broadcast type for the physical register file
// and its read-port bypass muxes.
package phys_reg_file_pkg;

  localparam int N                  = 2;
  localparam int PRF_SIZE           = 64;
  localparam int PRF_NUM_INDEX_BITS = $clog2(PRF_SIZE);
  localparam int XLEN               = 32;

  localparam logic [PRF_NUM_INDEX_BITS-1:0] PRF_ZERO = {PRF_NUM_INDEX_BITS{1'b0}};

  typedef struct packed {
    logic                          valid;
    logic [PRF_NUM_INDEX_BITS-1:0] dest_prf;
    logic [XLEN-1:0]               value;
    logic                          value_valid;
  } cdb_t;

  // Register 0 is hardwired, so a broadcast to it never counts as a write.
  function automatic logic cdb_writes(input cdb_t c);
    return c.valid && (c.dest_prf != PRF_ZERO);
  endfunction

  function automatic logic cdb_hits(input cdb_t c, input logic [PRF_NUM_INDEX_BITS-1:0] idx);
    return cdb_writes(c) && (c.dest_prf == idx);
  endfunction

endpackage

// File: rtl/prf_bypass_mux.sv
// One source-operand read port: forwards a same-cycle CDB result over the stored
// entry, highest-numbered matching lane taking precedence.
module prf_bypass_mux
  import phys_reg_file_pkg::*;
(
  input  logic [PRF_NUM_INDEX_BITS-1:0] rd_prf_i,
  input  logic [XLEN-1:0]               stored_value_i,
  input  logic                          stored_ready_i,
  input  cdb_t [N-1:0]                  cdb_i,
  output logic [XLEN-1:0]               rd_value_o,
  output logic                          rd_ready_o
);

  logic [XLEN-1:0] value_s;
  logic            ready_s;

  // A hit without value_valid still wakes the source but keeps the stored value.
  always_comb begin
    value_s = stored_value_i;
    ready_s = stored_ready_i;
    for (int i = 0; i < N; i++) begin
      ready_s = ready_s | cdb_hits(cdb_i[i], rd_prf_i);
      value_s = cdb_hits(cdb_i[i], rd_prf_i)
              ? (cdb_i[i].value_valid ? cdb_i[i].value : stored_value_i)
              : value_s;
    end
  end

  assign rd_value_o = value_s;
  assign rd_ready_o = ready_s;

endmodule

// File: rtl/phys_reg_file.sv
// Physical register file: CDB result writes, dispatch ready-clears, nuke restore,
// and 2N combinational read ports with same-cycle CDB bypass.
module phys_reg_file
  import phys_reg_file_pkg::*;
(
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  nuke,
  input  cdb_t [N-1:0]                          cdb_in,
  input  logic [N-1:0]                          alloc_valid,
  input  logic [N-1:0][PRF_NUM_INDEX_BITS-1:0]  alloc_prf,
  input  logic [2*N-1:0][PRF_NUM_INDEX_BITS-1:0] rd_prf,
  output logic [2*N-1:0][XLEN-1:0]              rd_value,
  output logic [2*N-1:0]                        rd_ready,
  output logic [PRF_SIZE-1:0]                   ready_bits,
  output logic                                  dup_write_err
);

  logic [XLEN-1:0]     value_q [PRF_SIZE];
  logic [XLEN-1:0]     value_d [PRF_SIZE];
  logic [PRF_SIZE-1:0] ready_q;
  logic [PRF_SIZE-1:0] ready_d;
  logic                dup_q;
  logic                dup_d;

  // Lanes applied in ascending order so the highest duplicate lane wins; allocation
  // then overrides the CDB ready-set, and nuke overrides both.
  always_comb begin
    value_d = value_q;
    ready_d = ready_q;
    for (int i = 0; i < N; i++) begin
      ready_d[cdb_in[i].dest_prf] = cdb_writes(cdb_in[i]) ? 1'b1 : ready_d[cdb_in[i].dest_prf];
      value_d[cdb_in[i].dest_prf] = (cdb_writes(cdb_in[i]) && cdb_in[i].value_valid)
                                  ? cdb_in[i].value : value_d[cdb_in[i].dest_prf];
    end
    for (int i = 0; i < N; i++) begin
      ready_d[alloc_prf[i]] = (alloc_valid[i] && !nuke) ? 1'b0 : ready_d[alloc_prf[i]];
    end
    ready_d    = nuke ? {PRF_SIZE{1'b1}} : ready_d;
    ready_d[0] = 1'b1;
    value_d[0] = {XLEN{1'b0}};
  end

  // Any pair of lanes writing the same nonzero register this cycle.
  always_comb begin
    dup_d = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        dup_d = dup_d | (cdb_writes(cdb_in[i]) && cdb_writes(cdb_in[j]) &&
                         (cdb_in[i].dest_prf == cdb_in[j].dest_prf));
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_q <= '{default: {XLEN{1'b0}}};
      ready_q <= {PRF_SIZE{1'b1}};
      dup_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ready_q <= ready_d;
      dup_q   <= dup_d;
    end
  end

  for (genvar j = 0; j < 2*N; j++) begin : g_rd
    prf_bypass_mux u_bypass (
      .rd_prf_i       (rd_prf[j]),
      .stored_value_i (value_q[rd_prf[j]]),
      .stored_ready_i (ready_q[rd_prf[j]]),
      .cdb_i          (cdb_in),
      .rd_value_o     (rd_value[j]),
      .rd_ready_o     (rd_ready[j])
    );
  end

  assign ready_bits    = ready_q;
  assign dup_write_err = dup_q;

endmodule

// File: tb/tb_phys_reg_file.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against an array-based reference model.
module tb_phys_reg_file;
  import phys_reg_file_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic nuke;
  cdb_t [N-1:0] cdb_in;
  logic [N-1:0] alloc_valid;
  logic [N-1:0][PRF_NUM_INDEX_BITS-1:0] alloc_prf;
  logic [2*N-1:0][PRF_NUM_INDEX_BITS-1:0] rd_prf;
  logic [2*N-1:0][XLEN-1:0] rd_value;
  logic [2*N-1:0] rd_ready;
  logic [PRF_SIZE-1:0] ready_bits;
  logic dup_write_err;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_value [PRF_SIZE];
  bit              m_ready [PRF_SIZE];
  bit              m_dup;
  bit              m_live = 1'b0;

  always #5 clock = ~clock;

  phys_reg_file dut (
    .clock         (clock),
    .reset         (reset),
    .nuke          (nuke),
    .cdb_in        (cdb_in),
    .alloc_valid   (alloc_valid),
    .alloc_prf     (alloc_prf),
    .rd_prf        (rd_prf),
    .rd_value      (rd_value),
    .rd_ready      (rd_ready),
    .ready_bits    (ready_bits),
    .dup_write_err (dup_write_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state update, evaluated from the inputs present at the clock edge.
  task automatic model_update();
    bit dup;
    dup = 1'b0;
    if (reset) begin
      for (int p = 0; p < PRF_SIZE; p++) begin
        m_value[p] = '0;
        m_ready[p] = 1'b1;
      end
      m_dup  = 1'b0;
      m_live = 1'b1;
    end else begin
      for (int a = 0; a < N; a++)
        for (int b = a + 1; b < N; b++)
          if (cdb_in[a].valid && cdb_in[b].valid && cdb_in[a].dest_prf == cdb_in[b].dest_prf
              && cdb_in[a].dest_prf != 0)
            dup = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (cdb_in[i].valid && cdb_in[i].dest_prf != 0) begin
          m_ready[cdb_in[i].dest_prf] = 1'b1;
          if (cdb_in[i].value_valid) m_value[cdb_in[i].dest_prf] = cdb_in[i].value;
        end
      end
      if (nuke) begin
        for (int p = 0; p < PRF_SIZE; p++) m_ready[p] = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (alloc_valid[i] && alloc_prf[i] != 0) m_ready[alloc_prf[i]] = 1'b0;
      end
      m_dup = dup;
    end
  endtask

  // Compare every output against the model for the currently applied inputs.
  task automatic compare();
    logic [XLEN-1:0]     ev;
    bit                  er;
    logic [PRF_SIZE-1:0] erb;
    int                  a;
    if (m_live) begin
      for (int j = 0; j < 2*N; j++) begin
        a  = int'(rd_prf[j]);
        ev = m_value[a];
        er = m_ready[a];
        if (a != 0) begin
          for (int i = N - 1; i >= 0; i--) begin
            if (cdb_in[i].valid && int'(cdb_in[i].dest_prf) == a) begin
              er = 1'b1;
              ev = cdb_in[i].value_valid ? cdb_in[i].value : m_value[a];
              break;
            end
          end
        end
        chk($sformatf("model rd_value[%0d] addr %0d", j, a), 64'(rd_value[j]), 64'(ev));
        chk($sformatf("model rd_ready[%0d] addr %0d", j, a), 64'(rd_ready[j]), 64'(er));
      end
      for (int p = 0; p < PRF_SIZE; p++) erb[p] = m_ready[p];
      chk("model ready_bits", 64'(ready_bits), 64'(erb));
      chk("model dup_write_err", 64'(dup_write_err), 64'(m_dup));
    end
  endtask

  task automatic settle();
    @(negedge clock);
    compare();
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle();
    reset       = 1'b0;
    nuke        = 1'b0;
    cdb_in      = '0;
    alloc_valid = '0;
    alloc_prf   = '0;
    rd_prf      = '0;
  endtask

  task automatic cdb(input int lane, input int dest, input logic [XLEN-1:0] v, input bit vv);
    cdb_in[lane].valid       = 1'b1;
    cdb_in[lane].dest_prf    = PRF_NUM_INDEX_BITS'(dest);
    cdb_in[lane].value       = v;
    cdb_in[lane].value_valid = vv;
  endtask

  task automatic alloc(input int lane, input int prf);
    alloc_valid[lane] = 1'b1;
    alloc_prf[lane]   = PRF_NUM_INDEX_BITS'(prf);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    idle();

    // Reset state on regs 0, 5, PRF_SIZE-1.
    rd_prf[0] = 6'd0;
    rd_prf[1] = 6'd5;
    rd_prf[2] = PRF_NUM_INDEX_BITS'(PRF_SIZE - 1);
    settle();
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("reset rd_value[%0d]", j), 64'(rd_value[j]), 64'h0);
      chk($sformatf("reset rd_ready[%0d]", j), 64'(rd_ready[j]), 64'h1);
    end
    chk("reset ready_bits", 64'(ready_bits), {64{1'b1}});
    chk("reset dup_write_err", 64'(dup_write_err), 64'h0);
    tick();

    // Allocate 7, observe ready clear, then CDB bypass and stored wakeup.
    idle(); alloc(0, 7); cyc();
    idle(); rd_prf[0] = 6'd7;
    settle();
    chk("alloc7 rd_ready", 64'(rd_ready[0]), 64'h0);
    chk("alloc7 ready_bits[7]", 64'(ready_bits[7]), 64'h0);
    tick();
    cyc();
    cdb(0, 7, 32'hDEADBEEF, 1'b1);
    settle();
    chk("bypass7 rd_value", 64'(rd_value[0]), 64'hDEADBEEF);
    chk("bypass7 rd_ready", 64'(rd_ready[0]), 64'h1);
    chk("bypass7 ready_bits[7] still 0", 64'(ready_bits[7]), 64'h0);
    tick();
    idle(); rd_prf[0] = 6'd7;
    settle();
    chk("stored7 ready_bits[7]", 64'(ready_bits[7]), 64'h1);
    chk("stored7 rd_value", 64'(rd_value[0]), 64'hDEADBEEF);
    tick();

    // Allocation beats same-cycle CDB ready-set, value still written.
    idle(); alloc(0, 9); cdb(0, 9, 32'h55, 1'b1); cyc();
    idle(); rd_prf[1] = 6'd9;
    settle();
    chk("alloc9 rd_ready", 64'(rd_ready[1]), 64'h0);
    chk("alloc9 rd_value", 64'(rd_value[1]), 64'h55);
    tick();

    // Duplicate CDB targets: highest lane wins, one-cycle error pulse.
    idle(); cdb(0, 12, 32'h11, 1'b1); cdb(1, 12, 32'h22, 1'b1); rd_prf[2] = 6'd12;
    settle();
    chk("dup12 bypass value", 64'(rd_value[2]), 64'h22);
    tick();
    idle(); rd_prf[2] = 6'd12;
    settle();
    chk("dup12 stored value", 64'(rd_value[2]), 64'h22);
    chk("dup12 err high", 64'(dup_write_err), 64'h1);
    tick();
    settle();
    chk("dup12 err cleared", 64'(dup_write_err), 64'h0);
    tick();

    // Nuke restores ready bits and drops same-cycle allocation.
    idle(); alloc(0, 3); alloc(1, 4); cyc();
    idle(); alloc(0, 8);
    settle();
    chk("pre-nuke ready_bits[3]", 64'(ready_bits[3]), 64'h0);
    tick();
    idle(); nuke = 1'b1; alloc(0, 10); cyc();
    idle();
    settle();
    chk("nuke ready_bits[3]", 64'(ready_bits[3]), 64'h1);
    chk("nuke ready_bits[4]", 64'(ready_bits[4]), 64'h1);
    chk("nuke ready_bits[8]", 64'(ready_bits[8]), 64'h1);
    chk("nuke ready_bits[10]", 64'(ready_bits[10]), 64'h1);
    tick();

    // Register 0 is hardwired.
    idle(); cdb(0, 0, 32'hFF, 1'b1); alloc(0, 0); rd_prf[3] = 6'd0;
    settle();
    chk("reg0 bypass value", 64'(rd_value[3]), 64'h0);
    chk("reg0 bypass ready", 64'(rd_ready[3]), 64'h1);
    tick();
    idle(); rd_prf[3] = 6'd0;
    settle();
    chk("reg0 stored value", 64'(rd_value[3]), 64'h0);
    chk("reg0 ready_bits[0]", 64'(ready_bits[0]), 64'h1);
    tick();

    // Non-writing CDB result sets ready but keeps the stored value.
    idle(); cdb(1, 6, 32'h10, 1'b1); cyc();
    idle(); alloc(1, 6); cyc();
    idle(); cdb(0, 6, 32'hAB, 1'b0); rd_prf[1] = 6'd6;
    settle();
    chk("reg6 nvv bypass value", 64'(rd_value[1]), 64'h10);
    chk("reg6 nvv bypass ready", 64'(rd_ready[1]), 64'h1);
    tick();
    idle(); rd_prf[1] = 6'd6;
    settle();
    chk("reg6 ready_bits[6]", 64'(ready_bits[6]), 64'h1);
    chk("reg6 stored value", 64'(rd_value[1]), 64'h10);
    tick();

    // Random traffic over a small index window to force collisions.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      nuke  = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N; i++) begin
        cdb_in[i].valid       = 1'($urandom_range(0, 1));
        cdb_in[i].dest_prf    = PRF_NUM_INDEX_BITS'($urandom_range(0, 15));
        cdb_in[i].value       = XLEN'($urandom);
        cdb_in[i].value_valid = ($urandom_range(0, 3) != 0);
        alloc_valid[i]        = ($urandom_range(0, 2) == 0);
        alloc_prf[i]          = PRF_NUM_INDEX_BITS'($urandom_range(0, 15));
      end
      for (int j = 0; j < 2*N; j++) begin
        rd_prf[j] = ($urandom_range(0, 7) == 0) ? PRF_NUM_INDEX_BITS'($urandom_range(0, PRF_SIZE - 1))
                                                : PRF_NUM_INDEX_BITS'($urandom_range(0, 15));
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
